// File: rtl/sonar_rec_pkg.sv
// rtl/sonar_rec_pkg.sv - Sonar record types, header layout, beat entry format and header builder
package sonar_rec_pkg;

    typedef enum logic [7:0] {
        REC_BEAT      = 8'd1,
        REC_END       = 8'd2,
        REC_TIMESTAMP = 8'd3
    } rec_type_e;

    localparam int HDR_TYPE_LSB  = 0;
    localparam int HDR_IFACE_LSB = 8;
    localparam int HDR_ARGC_LSB  = 16;

    localparam logic [7:0] ARGC_BEAT      = 8'd3;
    localparam logic [7:0] ARGC_END       = 8'd1;
    localparam logic [7:0] ARGC_TIMESTAMP = 8'd1;

    // Widest tdata/timestamp an entry can hold; narrower instances zero-extend into these fields.
    localparam int ENTRY_DATA_WIDTH = 64;
    localparam int ENTRY_TS_WIDTH   = 64;

    typedef struct packed {
        logic [ENTRY_DATA_WIDTH-1:0] tdata;
        logic                        tlast;
        logic [ENTRY_TS_WIDTH-1:0]   ts;
    } beat_entry_t;

    function automatic logic [31:0] make_header(rec_type_e recType, logic [7:0] iface, logic [7:0] argc);
        logic [31:0] hdr;
        hdr                     = '0;
        hdr[HDR_TYPE_LSB +: 8]  = recType;
        hdr[HDR_IFACE_LSB +: 8] = iface;
        hdr[HDR_ARGC_LSB +: 8]  = argc;
        return hdr;
    endfunction

    function automatic logic [7:0] argc_of(rec_type_e recType);
        return (recType == REC_BEAT) ? ARGC_BEAT :
               (recType == REC_END)  ? ARGC_END  : ARGC_TIMESTAMP;
    endfunction

endpackage

// File: rtl/sonar_sync_fifo.sv
// rtl/sonar_sync_fifo.sv - single-clock show-ahead FIFO with full/empty flags and fill level
module sonar_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full)
                wrPtr <= wrPtr + (AW+1)'(1);
            if (pop && !empty)
                rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wrPtr[AW-1:0]] <= wrData;
    end

    assign level  = wrPtr - rdPtr;
    assign empty  = (level == '0);
    assign full   = level[AW];
    assign rdData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/sonar_stream_recorder.sv
// rtl/sonar_stream_recorder.sv - passive AXI-Stream tap emitting timestamped Sonar BEAT/END/TIMESTAMP records
module sonar_stream_recorder
    import sonar_rec_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         TS_WIDTH   = 32,
    parameter logic [7:0] IFACE_ID   = 8'd0,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  enable,
    input  logic                  ts_init,
    input  logic                  vector_end,
    input  logic [15:0]           vector_id,
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    input  logic [DATA_WIDTH-1:0] mon_tdata,
    input  logic                  mon_tlast,
    output logic                  rec_tvalid,
    input  logic                  rec_tready,
    output logic [DATA_WIDTH-1:0] rec_tdata,
    output logic                  rec_tlast,
    output logic                  overflow,
    output logic [15:0]           drop_count
);
    typedef enum logic [2:0] {IDLE, HDR, ARG0, ARG1, ARG2} state_e;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_e                state;
    rec_type_e             srcType;
    rec_type_e             selType;
    logic [TS_WIDTH-1:0]   tsCount;
    logic                  tsPending;
    logic                  endPending;
    logic [15:0]           endId;
    logic [DATA_WIDTH-1:0] singleArg;

    beat_entry_t capEntry;
    beat_entry_t headEntry;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [LW-1:0] fifoLevel;

    logic capture, push, lastHs, popNow, beatAvail, endAvail, doSelect;

    assign capture  = enable & mon_tvalid & mon_tready;
    assign push     = capture & ~fifoFull;
    assign capEntry = '{tdata: ENTRY_DATA_WIDTH'(mon_tdata), tlast: mon_tlast, ts: ENTRY_TS_WIDTH'(tsCount)};

    // The head entry stays in the FIFO while its record is emitted, so the FIFO bounds
    // everything captured but not yet fully sent; it is popped on the record's last word.
    sonar_sync_fifo #(
        .WIDTH ($bits(beat_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .push   (push),
        .wrData (capEntry),
        .pop    (popNow),
        .rdData (headEntry),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .level  (fifoLevel)
    );

    assign lastHs    = rec_tvalid & rec_tready & rec_tlast;
    assign popNow    = lastHs & (srcType == REC_BEAT);
    assign beatAvail = popNow ? (fifoLevel > LW'(1)) : !fifoEmpty;
    assign endAvail  = endPending & (popNow ? (fifoLevel == LW'(1)) : fifoEmpty);
    assign doSelect  = ((state == IDLE) | lastHs) & (beatAvail | tsPending | endAvail);
    assign selType   = beatAvail ? REC_BEAT : (tsPending ? REC_TIMESTAMP : REC_END);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tsCount    <= '0;
            tsPending  <= 1'b0;
            endPending <= 1'b0;
            endId      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            tsCount <= ts_init ? '0 : tsCount + TS_WIDTH'(1);
            if (ts_init)
                tsPending <= 1'b1;
            else if (doSelect && selType == REC_TIMESTAMP)
                tsPending <= 1'b0;
            if (doSelect && selType == REC_END)
                endPending <= 1'b0;
            if (vector_end) begin
                if (endPending && !(doSelect && selType == REC_END))
                    overflow <= 1'b1;
                else begin
                    endPending <= 1'b1;
                    endId      <= vector_id;
                end
            end
            if (capture && fifoFull) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            srcType    <= REC_BEAT;
            singleArg  <= '0;
            rec_tvalid <= 1'b0;
            rec_tdata  <= '0;
            rec_tlast  <= 1'b0;
        end else if (doSelect) begin
            state      <= HDR;
            srcType    <= selType;
            singleArg  <= (selType == REC_END) ? DATA_WIDTH'(endId) : DATA_WIDTH'(tsCount);
            rec_tvalid <= 1'b1;
            rec_tdata  <= DATA_WIDTH'(make_header(selType, IFACE_ID, argc_of(selType)));
            rec_tlast  <= 1'b0;
        end else if (lastHs) begin
            state      <= IDLE;
            rec_tvalid <= 1'b0;
            rec_tdata  <= '0;
            rec_tlast  <= 1'b0;
        end else if (rec_tvalid && rec_tready) begin
            case (state)
                HDR: begin
                    state     <= ARG0;
                    rec_tdata <= (srcType == REC_BEAT) ? DATA_WIDTH'(headEntry.tdata) : singleArg;
                    rec_tlast <= (srcType != REC_BEAT);
                end
                ARG0: begin
                    state     <= ARG1;
                    rec_tdata <= DATA_WIDTH'(headEntry.tlast);
                end
                ARG1: begin
                    state     <= ARG2;
                    rec_tdata <= DATA_WIDTH'(headEntry.ts);
                    rec_tlast <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_stream_recorder.sv
// tb/tb_sonar_stream_recorder.sv - directed self-checking bench for sonar_stream_recorder
module tb_sonar_stream_recorder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, ts_init, vector_end;
    logic [15:0] vector_id;
    logic        mon_tvalid, mon_tready, mon_tlast;
    logic [63:0] mon_tdata;
    logic        rec_tvalid, rec_tready, rec_tlast;
    logic [63:0] rec_tdata;
    logic        overflow;
    logic [15:0] drop_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tsInitCyc = 0;
    int stallErr = 0;
    int bc [5];

    logic [63:0] wq [$];
    logic        lq [$];
    logic        stallHeld = 1'b0;
    logic [63:0] stallData;
    logic        stallLast;

    sonar_stream_recorder #(
        .DATA_WIDTH (64),
        .TS_WIDTH   (8),
        .IFACE_ID   (8'd0),
        .FIFO_DEPTH (16)
    ) dut (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .enable     (enable),
        .ts_init    (ts_init),
        .vector_end (vector_end),
        .vector_id  (vector_id),
        .mon_tvalid (mon_tvalid),
        .mon_tready (mon_tready),
        .mon_tdata  (mon_tdata),
        .mon_tlast  (mon_tlast),
        .rec_tvalid (rec_tvalid),
        .rec_tready (rec_tready),
        .rec_tdata  (rec_tdata),
        .rec_tlast  (rec_tlast),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_n) begin
            stallHeld = 1'b0;
        end else begin
            if (stallHeld && (!rec_tvalid || rec_tdata !== stallData || rec_tlast !== stallLast))
                stallErr++;
            if (rec_tvalid && rec_tready) begin
                wq.push_back(rec_tdata);
                lq.push_back(rec_tlast);
            end
            stallHeld = rec_tvalid && !rec_tready;
            stallData = rec_tdata;
            stallLast = rec_tlast;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic beat(input logic [63:0] d, input logic l);
        enable     = 1'b1;
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tdata  = d;
        mon_tlast  = l;
        step();
        mon_tvalid = 1'b0;
    endtask

    task automatic waitWords(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && wq.size() < n; i++)
            step();
        repeat (4) step();
        check({tag, " word count"}, 64'(wq.size()), 64'(n));
    endtask

    task automatic checkRecord(input string tag, input int base, input logic [63:0] d,
                               input logic [63:0] l, input logic [63:0] ts);
        check({tag, " header"}, wq[base], 64'h030001);
        check({tag, " tdata"}, wq[base+1], d);
        check({tag, " tlast arg"}, wq[base+2], l);
        check({tag, " ts"}, wq[base+3], ts);
        check({tag, " rec_tlast"}, {60'd0, lq[base], lq[base+1], lq[base+2], lq[base+3]}, 64'b0001);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        wq.delete();
        lq.delete();
    endtask

    function automatic logic [63:0] tsExp(input int c);
        return 64'((c - tsInitCyc - 1) & 255);
    endfunction

    initial begin
        rst_n = 1'b0; enable = 1'b0; ts_init = 1'b0; vector_end = 1'b0; vector_id = '0;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tdata = '0; mon_tlast = 1'b0; rec_tready = 1'b1;
        step();
        step();
        check("reset rec_tvalid", 64'(rec_tvalid), 64'd0);
        check("reset rec_tdata", rec_tdata, 64'd0);
        check("reset rec_tlast", 64'(rec_tlast), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset drop_count", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        step();

        // Single beat after ts_init: TIMESTAMP record, then BEAT with ts 5
        ts_init = 1'b1;
        tsInitCyc = cyc;
        step();
        ts_init = 1'b0;
        repeat (5) step();
        beat(64'hDEAD, 1'b1);
        check("latency N+1 idle", 64'(rec_tvalid), 64'd0);
        step();
        check("latency N+2 valid", 64'(rec_tvalid), 64'd1);
        check("latency N+2 header", rec_tdata, 64'h030001);
        waitWords("single", 6, 40);
        check("ts record header", wq[0], 64'h010003);
        check("ts record arg", wq[1], 64'd0);
        check("ts record rec_tlast", {62'd0, lq[0], lq[1]}, 64'b01);
        checkRecord("single beat", 2, 64'hDEAD, 64'd1, 64'd5);
        enable = 1'b0;
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tdata = 64'h99;
        step();
        enable = 1'b1; mon_tready = 1'b0;
        step();
        mon_tvalid = 1'b0;
        repeat (8) step();
        check("ignored beats", 64'(wq.size()), 64'd6);

        // Backpressure: rec_tready toggles every cycle
        wq.delete(); lq.delete(); stallErr = 0;
        for (int i = 1; i <= 4; i++) begin
            rec_tready = ~rec_tready;
            bc[i] = cyc;
            beat(64'(i), (i == 4));
        end
        for (int i = 0; i < 200 && wq.size() < 16; i++) begin
            rec_tready = ~rec_tready;
            step();
        end
        rec_tready = 1'b1;
        waitWords("backpressure", 16, 10);
        for (int i = 1; i <= 4; i++)
            checkRecord($sformatf("bp beat %0d", i), 4*(i-1), 64'(i), 64'(i == 4), tsExp(bc[i]));
        check("bp stall stability", 64'(stallErr), 64'd0);

        // Overflow: 20 beats into a stalled recorder
        wq.delete(); lq.delete(); stallErr = 0;
        check("pre-overflow flag", 64'(overflow), 64'd0);
        rec_tready = 1'b0;
        for (int i = 1; i <= 20; i++)
            beat(64'(i), 1'b0);
        step();
        step();
        check("overflow drop_count", 64'(drop_count), 64'd4);
        check("overflow flag", 64'(overflow), 64'd1);
        rec_tready = 1'b1;
        waitWords("overflow drain", 64, 400);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("ovf rec %0d header", k), wq[4*k], 64'h030001);
            check($sformatf("ovf rec %0d tdata", k), wq[4*k+1], 64'(k+1));
        end
        check("ovf stall stability", 64'(stallErr), 64'd0);

        // End ordering: beat and vector_end in the same cycle
        doReset();
        rec_tready = 1'b1;
        vector_end = 1'b1; vector_id = 16'd7;
        beat(64'hA5, 1'b0);
        vector_end = 1'b0;
        waitWords("end order", 6, 40);
        check("end order beat header", wq[0], 64'h030001);
        check("end order beat tdata", wq[1], 64'hA5);
        check("end order beat rec_tlast", 64'(lq[3]), 64'd1);
        check("end order END header", wq[4], 64'h010002);
        check("end order END arg", wq[5], 64'd7);
        check("end order END rec_tlast", 64'(lq[5]), 64'd1);
        check("end order no overflow", 64'(overflow), 64'd0);

        // Second vector_end while the first is still pending
        wq.delete(); lq.delete();
        rec_tready = 1'b0;
        vector_end = 1'b1; vector_id = 16'd7;
        beat(64'h5A, 1'b1);
        vector_id = 16'd9;
        step();
        vector_end = 1'b0;
        repeat (3) step();
        check("dup end overflow", 64'(overflow), 64'd1);
        rec_tready = 1'b1;
        waitWords("dup end", 6, 40);
        check("dup end beat tdata", wq[1], 64'h5A);
        check("dup end header", wq[4], 64'h010002);
        check("dup end kept id", wq[5], 64'd7);

        // Timestamp wrap with TS_WIDTH=8
        wq.delete(); lq.delete();
        ts_init = 1'b1;
        tsInitCyc = cyc;
        step();
        ts_init = 1'b0;
        while (cyc < tsInitCyc + 256)
            step();
        beat(64'h11, 1'b1);
        step();
        beat(64'h22, 1'b0);
        waitWords("wrap", 10, 60);
        check("wrap ts header", wq[0], 64'h010003);
        checkRecord("wrap beat 255", 2, 64'h11, 64'd1, 64'd255);
        checkRecord("wrap beat 1", 6, 64'h22, 64'd0, 64'd1);

        // Reset asserted while the first record is in ARG1
        wq.delete(); lq.delete();
        rec_tready = 1'b0;
        for (int i = 1; i <= 18; i++)
            beat(64'(256 + i), i[0]);
        step();
        step();
        check("pre-reset drop_count", 64'(drop_count), 64'd2);
        rec_tready = 1'b1;
        step();
        step();
        check("ARG1 valid", 64'(rec_tvalid), 64'd1);
        check("ARG1 word", rec_tdata, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset rec_tvalid", 64'(rec_tvalid), 64'd0);
        check("async reset rec_tdata", rec_tdata, 64'd0);
        check("async reset drop_count", 64'(drop_count), 64'd0);
        check("async reset overflow", 64'(overflow), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        wq.delete(); lq.delete();
        beat(64'hBEEF, 1'b0);
        waitWords("post reset", 4, 40);
        check("post reset header", wq[0], 64'h030001);
        check("post reset tdata", wq[1], 64'hBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
